// File: rtl/trigger_level.sv
// Trigger level holder: keeps the on-screen trigger row, maps it back into the
// 14-bit sample domain, and runs an arm/prime/fire trigger search with hysteresis.
module trigger_level #(
  parameter int unsigned Y_MAX   = 119,
  parameter int unsigned Y_RESET = 60,
  parameter int unsigned HYST    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] in_y,
  input  logic        sample_valid,
  input  logic [2:0]  sel_lines,
  input  logic [1:0]  offset_sel,
  input  logic        level_up,
  input  logic        level_down,
  input  logic        arm,
  input  logic        trig_slope,
  output logic [7:0]  level_y,
  output logic [13:0] level_sample,
  output logic        armed,
  output logic        trig
);

  localparam int unsigned SW = 14;
  localparam int unsigned YW = 8;
  localparam int unsigned TW = 12;
  localparam int unsigned VW = 24;
  localparam int unsigned HW = 15;
  localparam logic [SW-1:0] S_MAX = SW'(16383);
  localparam logic [SW-1:0] S_MID = SW'(8192);

  typedef enum logic [1:0] {IDLE, PRIME, READY, FIRE} state_t;

  // Trigger row counter, saturating at both ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_y <= YW'(Y_RESET);
    end else if (level_up && !level_down && (level_y < YW'(Y_MAX))) begin
      level_y <= level_y + YW'(1);
    end else if (level_down && !level_up && (level_y != '0)) begin
      level_y <= level_y - YW'(1);
    end
  end

  // Scale select decode: shift amount and row constant of the display mapping
  logic [3:0]           shift_c;
  logic signed [TW-1:0] k_c;
  logic signed [TW-1:0] ofs_c;
  logic signed [TW-1:0] t_c;

  always_comb begin
    shift_c = 4'd7;
    k_c     = 12'sd4;
    ofs_c   = 12'sd0;
    case (sel_lines)
      3'b000:  begin shift_c = 4'd7;  k_c = 12'sd4;   end
      3'b001:  begin shift_c = 4'd6;  k_c = 12'sd68;  end
      3'b010:  begin shift_c = 4'd5;  k_c = 12'sd196; end
      3'b011:  begin shift_c = 4'd4;  k_c = 12'sd452; end
      3'b100:  begin shift_c = 4'd7;  k_c = 12'sd4;   end
      3'b101:  begin shift_c = 4'd8;  k_c = -12'sd28; end
      3'b110:  begin shift_c = 4'd9;  k_c = -12'sd44; end
      default: begin shift_c = 4'd10; k_c = -12'sd52; end
    endcase
    case (offset_sel)
      2'b00:   ofs_c = 12'sd0;
      2'b01:   ofs_c = 12'sd20;
      2'b10:   ofs_c = 12'sd40;
      default: ofs_c = -12'sd20;
    endcase
    t_c = $signed({4'b0000, level_y}) + k_c - ofs_c;
  end

  // Stage 1 register; valid flag keeps level_sample at its reset value until real data arrives
  logic                 s1_valid;
  logic signed [TW-1:0] t_q;
  logic [3:0]           shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      t_q      <= '0;
      shift_q  <= '0;
    end else begin
      s1_valid <= 1'b1;
      t_q      <= t_c;
      shift_q  <= shift_c;
    end
  end

  // Stage 2: shift back into sample units and clamp to the ADC range
  logic signed [VW-1:0] v_c;
  logic [SW-1:0]        ls_c;

  always_comb begin
    v_c  = VW'(t_q) <<< shift_q;
    ls_c = v_c[SW-1:0];
    if (t_q[TW-1]) begin
      ls_c = '0;
    end else if (|v_c[VW-1:SW]) begin
      ls_c = S_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_sample <= S_MID;
    end else if (s1_valid) begin
      level_sample <= ls_c;
    end
  end

  // Hysteresis thresholds around the current level, saturated to the sample range
  logic [HW-1:0] lo_w;
  logic [HW-1:0] hi_w;
  logic [SW-1:0] lo_c;
  logic [SW-1:0] hi_c;

  always_comb begin
    lo_w = {1'b0, level_sample} - HW'(HYST);
    hi_w = {1'b0, level_sample} + HW'(HYST);
    lo_c = lo_w[HW-1] ? '0 : lo_w[SW-1:0];
    hi_c = (hi_w > {1'b0, S_MAX}) ? S_MAX : hi_w[SW-1:0];
  end

  // Trigger FSM
  state_t        state;
  state_t        state_n;
  logic          armed_n;
  logic          trig_n;
  logic          slope_q;
  logic [SW-1:0] ls_prev;
  logic          slope_chg_c;
  logic          ls_chg_c;

  always_comb begin
    state_n     = state;
    slope_chg_c = (trig_slope != slope_q);
    ls_chg_c    = (level_sample != ls_prev);
    case (state)
      IDLE: state_n = IDLE;
      PRIME: begin
        if (slope_chg_c) begin
          state_n = PRIME;
        end else if (sample_valid && (trig_slope ? (in_y > hi_c) : (in_y < lo_c))) begin
          state_n = READY;
        end
      end
      READY: begin
        if (slope_chg_c || ls_chg_c) begin
          state_n = PRIME;
        end else if (sample_valid &&
                     (trig_slope ? (in_y <= level_sample) : (in_y >= level_sample))) begin
          state_n = FIRE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (arm) begin
      state_n = PRIME;
    end
    armed_n = (state_n == PRIME) || (state_n == READY);
    trig_n  = (state_n == FIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      trig    <= 1'b0;
      slope_q <= 1'b0;
      ls_prev <= S_MID;
    end else begin
      state   <= state_n;
      armed   <= armed_n;
      trig    <= trig_n;
      slope_q <= trig_slope;
      ls_prev <= level_sample;
    end
  end

endmodule

// File: tb/tb_trigger_level.sv
// Bench for trigger_level: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the level map and trigger search.
module tb_trigger_level;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] in_y = '0;
  logic        sample_valid = 1'b0;
  logic [2:0]  sel_lines = '0;
  logic [1:0]  offset_sel = '0;
  logic        level_up = 1'b0;
  logic        level_down = 1'b0;
  logic        arm = 1'b0;
  logic        trig_slope = 1'b0;
  logic [7:0]  level_y;
  logic [13:0] level_sample;
  logic        armed;
  logic        trig;

  always #5 clk = ~clk;

  trigger_level dut (
    .clk(clk), .rst_n(rst_n), .in_y(in_y), .sample_valid(sample_valid),
    .sel_lines(sel_lines), .offset_sel(offset_sel), .level_up(level_up),
    .level_down(level_down), .arm(arm), .trig_slope(trig_slope),
    .level_y(level_y), .level_sample(level_sample), .armed(armed), .trig(trig)
  );

  int total = 0;
  int bad = 0;

  int kk[8]   = '{4, 68, 196, 452, 4, -28, -44, -52};
  int sh[8]   = '{7, 6, 5, 4, 7, 8, 9, 10};
  int offr[4] = '{0, 20, 40, -20};

  // Model state: row, delayed sample level, and the search expressed as flags
  int m_ly, m_ls, m_ls_prev, m_p1;
  bit m_p1v, m_search, m_primed, m_fire, m_slope;

  function automatic int inv_map(input int ly, input int sel, input int off);
    int t, v;
    t = ly + kk[sel] - offr[off];
    if (t < 0) return 0;
    v = t << sh[sel];
    if (v > 16383) return 16383;
    return v;
  endfunction

  task automatic model_reset();
    m_ly = 60; m_ls = 8192; m_ls_prev = 8192; m_p1 = 0; m_p1v = 0;
    m_search = 0; m_primed = 0; m_fire = 0; m_slope = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int lo, hi, smp;
      bit ls_chg, sl_chg, n_search, n_primed, n_fire;
      smp = int'(in_y);
      lo = (m_ls - 64 < 0) ? 0 : m_ls - 64;
      hi = (m_ls + 64 > 16383) ? 16383 : m_ls + 64;
      ls_chg = (m_ls != m_ls_prev);
      sl_chg = (trig_slope != m_slope);
      n_search = m_search; n_primed = m_primed; n_fire = 0;
      if (arm) begin
        n_search = 1; n_primed = 0;
      end else if (m_fire) begin
        n_search = 0; n_primed = 0;
      end else if (m_search) begin
        if (sl_chg || (m_primed && ls_chg)) begin
          n_primed = 0;
        end else if (sample_valid) begin
          if (!m_primed) begin
            if (trig_slope ? (smp > hi) : (smp < lo)) n_primed = 1;
          end else if (trig_slope ? (smp <= m_ls) : (smp >= m_ls)) begin
            n_search = 0; n_primed = 0; n_fire = 1;
          end
        end
      end
      m_search = n_search; m_primed = n_primed; m_fire = n_fire;
      m_slope = trig_slope;
      m_ls_prev = m_ls;
      if (m_p1v) m_ls = m_p1;
      m_p1 = inv_map(m_ly, int'(sel_lines), int'(offset_sel));
      m_p1v = 1;
      if (level_up && !level_down && m_ly < 119) m_ly = m_ly + 1;
      else if (level_down && !level_up && m_ly > 0) m_ly = m_ly - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("level_y", int'(level_y), m_ly);
    chk("level_sample", int'(level_sample), m_ls);
    chk("armed", int'(armed), int'(m_search));
    chk("trig", int'(trig), int'(m_fire));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int v);
    in_y = 14'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    chk("rst_level_y", int'(level_y), 60);
    chk("rst_level_sample", int'(level_sample), 8192);
    chk("rst_armed", int'(armed), 0);
    chk("rst_trig", int'(trig), 0);
    ticks(2);
    sel_lines = 3'b011;
    ticks(2);
    chk("sel011_centre", int'(level_sample), 8192);

    // Inverse map and its two-cycle latency
    sel_lines = 3'b000; offset_sel = 2'b10;
    tick();
    chk("map_latency_old", int'(level_sample), 8192);
    tick();
    chk("map_off40", int'(level_sample), 3072);
    offset_sel = 2'b11;
    level_up = 1'b1;
    ticks(70);
    level_up = 1'b0;
    chk("up_saturate", int'(level_y), 119);
    ticks(2);
    chk("clamp_high", int'(level_sample), 16383);
    level_up = 1'b1; level_down = 1'b1;
    tick();
    level_up = 1'b0; level_down = 1'b0;
    chk("up_down_same", int'(level_y), 119);
    level_down = 1'b1;
    ticks(130);
    level_down = 1'b0;
    chk("down_saturate", int'(level_y), 0);
    level_up = 1'b1;
    ticks(60);
    level_up = 1'b0;
    chk("back_to_60", int'(level_y), 60);
    sel_lines = 3'b111; offset_sel = 2'b01;
    ticks(2);
    chk("clamp_low", int'(level_sample), 0);
    sel_lines = 3'b000; offset_sel = 2'b00;
    ticks(3);
    chk("centre_again", int'(level_sample), 8192);

    // Rising trigger
    pulse_arm();
    chk("rise_armed", int'(armed), 1);
    send(8150);
    send(8100);
    chk("rise_ready_armed", int'(armed), 1);
    send(8150);
    chk("rise_no_trig", int'(trig), 0);
    send(8192);
    chk("rise_trig", int'(trig), 1);
    tick();
    chk("rise_trig_once", int'(trig), 0);
    chk("rise_disarm", int'(armed), 0);

    // Falling trigger, then a search that never primes
    trig_slope = 1'b1;
    tick();
    pulse_arm();
    send(8300);
    send(8250);
    chk("fall_no_trig", int'(trig), 0);
    send(8192);
    chk("fall_trig", int'(trig), 1);
    pulse_arm();
    send(8200); send(8230); send(8255); send(8256); send(8100);
    chk("fall_stay_armed", int'(armed), 1);
    chk("fall_stay_quiet", int'(trig), 0);

    // Level change, re-arm and reset while READY
    trig_slope = 1'b0;
    tick();
    send(8100);
    level_up = 1'b1;
    tick();
    level_up = 1'b0;
    ticks(2);
    chk("level_moved", int'(level_sample), 8320);
    send(8400);
    chk("abort_no_trig", int'(trig), 0);
    chk("abort_armed", int'(armed), 1);
    send(8000);
    pulse_arm();
    send(8400);
    chk("rearm_no_trig", int'(trig), 0);
    send(8000);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_armed", int'(armed), 0);
    chk("rst_mid_trig", int'(trig), 0);
    tick();
    rst_n = 1'b1;
    send(8400);
    chk("post_rst_trig", int'(trig), 0);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      int v;
      arm        = ($urandom_range(0, 39) == 0);
      level_up   = ($urandom_range(0, 15) == 0);
      level_down = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) trig_slope = ~trig_slope;
      if ($urandom_range(0, 299) == 0) sel_lines = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) offset_sel = 2'($urandom_range(0, 3));
      sample_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 16383));
      else v = m_ls + int'($urandom_range(0, 400)) - 200;
      if (v < 0) v = 0;
      if (v > 16383) v = 16383;
      in_y = 14'(v);
      tick();
    end
    arm = 1'b0; level_up = 1'b0; level_down = 1'b0; sample_valid = 1'b0;
    ticks(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
